// File: rtl/dop_pkg.sv
// Shared definitions for the Doppler ramp controller and the freq_dop interface.
package dop_pkg;

   localparam int FREQ_W_DEF    = 28;
   localparam int INTV_W_DEF    = 24;
   localparam int LOAD_HOLD_DEF = 4;
   localparam int FREQ_BUS_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CALC    = 3'd1,
      ST_LOAD_HI = 3'd2,
      ST_LOAD_LO = 3'd3,
      ST_WAIT    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/dop_load_pulse.sv
// Load strobe generator: a trigger yields LOAD_HOLD clocks high then LOAD_HOLD clocks low.
// hi_last flags the final high clock, done flags the final low clock.
module dop_load_pulse #(
   parameter int LOAD_HOLD = 4
) (
   input  logic I_clk,
   input  logic I_reset,
   input  logic trig,
   output logic load,
   output logic hi_last,
   output logic done
);

   localparam int CW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

   logic [CW-1:0] cnt;
   logic          hi;
   logic          lo;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         hi  <= 1'b0;
         lo  <= 1'b0;
         cnt <= '0;
      end else if (trig) begin
         hi  <= 1'b1;
         lo  <= 1'b0;
         cnt <= CW'(LOAD_HOLD - 1);
      end else if (hi) begin
         if (cnt == '0) begin
            hi  <= 1'b0;
            lo  <= 1'b1;
            cnt <= CW'(LOAD_HOLD - 1);
         end else begin
            cnt <= cnt - 1'b1;
         end
      end else if (lo) begin
         if (cnt == '0) begin
            lo <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign load    = hi;
   assign hi_last = hi && (cnt == '0);
   assign done    = lo && (cnt == '0);

endmodule

// File: rtl/dop_ramp_ctrl.sv
// Steps the freq_dop period word from its current value to a target in clamped steps.
// Optional load counter output O_step_cnt is built when DOP_RAMP_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for I_start
// CALC    | compute and register the next word
// LOAD_HI | O_load high for LOAD_HOLD clocks
// LOAD_LO | O_load low for LOAD_HOLD clocks
// WAIT    | latched interval between steps
// DONE    | one-cycle O_done, back to IDLE
module dop_ramp_ctrl
   import dop_pkg::*;
#(
   parameter int FREQ_W    = FREQ_W_DEF,
   parameter int INTV_W    = INTV_W_DEF,
   parameter int LOAD_HOLD = LOAD_HOLD_DEF
) (
   input  logic                  I_clk,
   input  logic                  I_reset,
   input  logic                  I_start,
   input  logic                  I_abort,
   input  logic [FREQ_W-1:0]     I_target,
   input  logic [FREQ_W-1:0]     I_step,
   input  logic [INTV_W-1:0]     I_intv,
   output logic [FREQ_BUS_W-1:0] O_freq,
   output logic                  O_load,
   output logic                  O_busy,
   output logic                  O_done
`ifdef DOP_RAMP_CNT_EN
   ,
   output logic [15:0]           O_step_cnt
`endif
);

   state_t state;
   state_t state_nx;

   // cur is also the word presented on O_freq; both only move in CALC
   logic [FREQ_W-1:0] cur;
   logic [FREQ_W-1:0] tgt;
   logic [FREQ_W-1:0] stp;
   logic [INTV_W-1:0] intv;
   logic [INTV_W-1:0] wcnt;
   logic              abort_flg;
   logic              trig;
   logic              p_hi_last;
   logic              p_done;

   logic [FREQ_W:0]   sum;
   logic [FREQ_W:0]   diff;
   logic [FREQ_W-1:0] nxt;

   always_comb begin
      sum  = {1'b0, cur} + {1'b0, stp};
      diff = {1'b0, cur} - {1'b0, stp};
      nxt  = tgt;
      if (stp != '0) begin
         if (cur < tgt) begin
            if (sum <= {1'b0, tgt}) nxt = sum[FREQ_W-1:0];
         end else if (cur > tgt) begin
            if (!diff[FREQ_W] && (diff[FREQ_W-1:0] >= tgt)) nxt = diff[FREQ_W-1:0];
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (I_start && !I_abort) state_nx = ST_CALC;
         ST_CALC:    state_nx = I_abort ? ST_IDLE : ST_LOAD_HI;
         ST_LOAD_HI: if (p_hi_last) state_nx = ST_LOAD_LO;
         ST_LOAD_LO: begin
            if (p_done) begin
               if (abort_flg || I_abort) state_nx = ST_IDLE;
               else if (cur == tgt)      state_nx = ST_DONE;
               else if (intv == '0)      state_nx = ST_CALC;
               else                      state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (I_abort)          state_nx = ST_IDLE;
            else if (wcnt == '0)  state_nx = ST_CALC;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      O_busy = (state != ST_IDLE);
      O_done = (state == ST_DONE);
      trig   = (state == ST_CALC) && !I_abort;
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         cur       <= '0;
         tgt       <= '0;
         stp       <= '0;
         intv      <= '0;
         wcnt      <= '0;
         abort_flg <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && I_start && !I_abort) begin
            tgt  <= I_target;
            stp  <= I_step;
            intv <= I_intv;
         end
         if (trig) cur <= nxt;
         if (state_nx == ST_IDLE)
            abort_flg <= 1'b0;
         else if (((state == ST_LOAD_HI) || (state == ST_LOAD_LO)) && I_abort)
            abort_flg <= 1'b1;
         if ((state == ST_LOAD_LO) && p_done)
            wcnt <= intv - 1'b1;
         else if ((state == ST_WAIT) && (wcnt != '0))
            wcnt <= wcnt - 1'b1;
      end
   end

   assign O_freq = FREQ_BUS_W'(cur);

   dop_load_pulse #(
      .LOAD_HOLD(LOAD_HOLD)
   ) u_load_pulse (
      .I_clk   (I_clk),
      .I_reset (I_reset),
      .trig    (trig),
      .load    (O_load),
      .hi_last (p_hi_last),
      .done    (p_done)
   );

`ifdef DOP_RAMP_CNT_EN
   always_ff @(posedge I_clk) begin
      if (I_reset)                          O_step_cnt <= '0;
      else if (trig && (O_step_cnt != 16'hFFFF)) O_step_cnt <= O_step_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/dop_ramp_ctrl.md
DOP_RAMP_CTRL -- requirements
Module: dop_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter FREQ_W, default 28, giving the width of the period word loaded into freq_dop.
REQ-002 The block SHALL have parameter INTV_W, default 24, giving the width of the inter-step interval counter.
REQ-003 The block SHALL have parameter LOAD_HOLD, default 4, giving the O_load high time and the minimum low time, in clocks.
REQ-004 The block SHALL have port I_clk, input, 1 bit: the single clock, 25 MHz.
REQ-005 The block SHALL have port I_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port I_start, input, 1 bit: one-cycle ramp start request.
REQ-007 The block SHALL have port I_abort, input, 1 bit: one-cycle ramp abort request.
REQ-008 The block SHALL have port I_target, input, FREQ_W bits: final period word.
REQ-009 The block SHALL have port I_step, input, FREQ_W bits: step magnitude per load.
REQ-010 The block SHALL have port I_intv, input, INTV_W bits: idle clocks between steps.
REQ-011 The block SHALL have port O_freq, output, 32 bits: period word to freq_dop I_freq, with bits above FREQ_W at zero.
REQ-012 The block SHALL have port O_load, output, 1 bit: load strobe to freq_dop I_load.
REQ-013 The block SHALL have port O_busy, output, 1 bit: high while a ramp is in progress.
REQ-014 The block SHALL have port O_done, output, 1 bit: one-cycle pulse when the ramp reaches the target.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC, LOAD_HI, LOAD_LO, WAIT and DONE.
REQ-016 In IDLE, I_start SHALL latch I_target, I_step and I_intv, and the FSM SHALL enter CALC on the next cycle.
REQ-017 I_start SHALL be ignored outside IDLE.
REQ-018 CALC SHALL compute the next word from the current word (cur): cur+step if cur<target, cur-step if cur>target, clamped to target, and equal to target if step==0 or cur==target.
REQ-019 The arithmetic in CALC SHALL use FREQ_W+1 bits so that no wrap-around can occur.
REQ-020 CALC SHALL register the result into O_freq and cur, and the FSM SHALL then enter LOAD_HI; CALC lasts exactly 1 cycle.
REQ-021 O_load SHALL be 1 for exactly LOAD_HOLD cycles in LOAD_HI, then 0 for exactly LOAD_HOLD cycles in LOAD_LO.
REQ-022 O_freq SHALL change only in CALC and SHALL be stable at all other times.
REQ-023 At the end of LOAD_LO: if cur==target the FSM SHALL enter DONE; else it SHALL enter WAIT for the latched I_intv cycles (0 means pass straight through), then CALC.
REQ-024 DONE SHALL assert O_done for 1 cycle and then return to IDLE.
REQ-025 O_busy SHALL be 1 in every state except IDLE.
REQ-026 If I_start arrives with target==cur, the block SHALL still issue exactly one load of that word.
REQ-027 I_abort in CALC or WAIT SHALL force IDLE on the next cycle, with no O_done.
REQ-028 I_abort in LOAD_HI or LOAD_LO SHALL be latched and taken at the end of LOAD_LO (pulse never truncated), with no O_done.
REQ-029 In IDLE, I_start and I_abort in the same cycle SHALL resolve with abort winning and no ramp started.
REQ-030 On abort, O_freq SHALL hold its last loaded value.

Reset
REQ-031 When I_reset is sampled high, the block SHALL set state=IDLE, O_freq=0, cur=0, O_load=0, O_busy=0, O_done=0 and clear all latched inputs, counters and the abort flag on the next edge, including mid-pulse.

Configuration
REQ-032 When DOP_RAMP_CNT_EN is defined, the block SHALL add output O_step_cnt, 16 bits, counting loads issued since reset, saturating at 16'hFFFF and cleared by I_reset.
REQ-033 When DOP_RAMP_CNT_EN is undefined, the O_step_cnt port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-034 The shared package dop_pkg SHALL hold the FSM state encoding, the FREQ_W/INTV_W/LOAD_HOLD defaults and the 32-bit I_freq bus width shared with freq_dop.
REQ-035 The sub-module dop_load_pulse SHALL implement the LOAD_HI/LOAD_LO timing: it accepts a one-cycle trigger, produces an O_load of LOAD_HOLD high followed by LOAD_HOLD low, and returns a completion pulse.

Verification
REQ-036 The bench SHALL cover: I_reset held 2 cycles -> O_freq=0, O_load=0, O_busy=0, O_done=0.
REQ-037 The bench SHALL cover: cur=0, start target=1000, step=300, intv=10 -> loads of 300, 600, 900, 1000; each O_load high 4 cycles; load rising edges 19 cycles apart; O_done 1 cycle after the final LOAD_LO.
REQ-038 The bench SHALL cover: cur=1000, target=100, step=400, intv=0 -> loads of 600, 200, 100; edges 9 cycles apart.
REQ-039 The bench SHALL cover: step=0, target=5000 -> single load of 5000, then O_done.
REQ-040 The bench SHALL cover: abort in WAIT after the 600 load -> IDLE next cycle, O_freq=600, no O_done; and I_start during busy is ignored.
REQ-041 The bench SHALL cover: I_reset in the 2nd cycle of LOAD_HI -> next cycle O_load=0, O_freq=0, O_busy=0; and with DOP_RAMP_CNT_EN defined, O_step_cnt=4 after the REQ-037 ramp.
